lsu_pipe: RTL and testbench



---
 rtl/lsu_pipe.sv | 199 +++++++++++++++++++
 tb/tb_lsu_pipe.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_pipe.sv
// Load/store unit: effective address, single-outstanding dmem access, lane alignment, CDB result FIFO.
// Latency: accept -> dmem request next cycle; result visible on CDB the cycle after dmem_resp.
// Backpressure: rvs_rdy drops while an op is in flight or the result buffer is full; CDB pops on cdb_req && cdb_rdy.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word ops trap (cdb_exc=1) instead of being force-aligned.
module lsu_pipe #(
  parameter int TAG_W = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rvs_req,
  output logic             rvs_rdy,
  input  logic [3:0]       rvs_opc,
  input  logic [TAG_W-1:0] rvs_tag,
  input  logic [31:0]      rvs_rs1,
  input  logic [31:0]      rvs_rs2,
  input  logic [31:0]      rvs_imm,
  output logic [31:0]      dmem_addr,
  output logic [3:0]       dmem_rmask,
  output logic [3:0]       dmem_wmask,
  output logic [31:0]      dmem_wdata,
  input  logic [31:0]      dmem_rdata,
  input  logic             dmem_resp,
  output logic             cdb_req,
  input  logic             cdb_rdy,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [31:0]      cdb_wdata,
  output logic             cdb_exc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic {IDLE, MEM} state_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
    logic             exc;
  } ent_t;

  state_t           state;
  logic [3:0]       opc_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      addr_q;
  logic [31:0]      rs2_q;
  logic             mis_q;

  ent_t             buf_q [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] count;

  logic             acc;
  logic             pending;
  logic             push;
  logic             pop;
  logic [31:0]      eff_addr;
  logic             sz_byte;
  logic             sz_half;
  logic             sz_word;
  logic [1:0]       off;
  logic [3:0]       mask_base;
  logic [3:0]       mask;
  logic             mem_active;
  logic [31:0]      sh;
  logic [31:0]      ld_data;
  ent_t             push_ent;
  ent_t             head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign eff_addr = rvs_rs1 + rvs_imm;

  // An op in flight already owns a reserved buffer slot, so accept only when idle with space left.
  assign pending = (state != IDLE);
  assign rvs_rdy = !rst && !pending && (count < CNT_FULL);
  assign acc     = rvs_req && rvs_rdy;

  // Size decode of the latched op; reserved size 11 behaves as a word.
  assign sz_byte = (opc_q[1:0] == 2'b00);
  assign sz_half = (opc_q[1:0] == 2'b01);
  assign sz_word = opc_q[1];

  // Byte offset forced to natural alignment; trapping builds never issue misaligned ops anyway.
  assign off       = sz_word ? 2'b00 : (sz_half ? {addr_q[1], 1'b0} : addr_q[1:0]);
  assign mask_base = sz_byte ? 4'b0001 : (sz_half ? 4'b0011 : 4'b1111);
  assign mask      = mask_base << off;

  assign mem_active = (state == MEM) && !mis_q;
  assign dmem_addr  = {addr_q[31:2], 2'b00};
  assign dmem_rmask = (mem_active && !opc_q[3]) ? mask : 4'b0000;
  assign dmem_wmask = (mem_active &&  opc_q[3]) ? mask : 4'b0000;
  assign dmem_wdata = rs2_q << {off, 3'b000};

  assign sh = dmem_rdata >> {off, 3'b000};

  // Load lane extraction with sign or zero extension for sub-word sizes.
  always_comb begin
    ld_data = sh;
    if (sz_byte) begin
      ld_data = {{24{!opc_q[2] && sh[7]}}, sh[7:0]};
    end else if (sz_half) begin
      ld_data = {{16{!opc_q[2] && sh[15]}}, sh[15:0]};
    end
  end

  // A trapped op completes without touching memory; otherwise wait for the response pulse.
  assign push          = (state == MEM) && (mis_q || dmem_resp);
  assign push_ent.tag  = tag_q;
  assign push_ent.data = mis_q ? addr_q : (opc_q[3] ? 32'd0 : ld_data);
  assign push_ent.exc  = mis_q;

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_in;
  assign mis_in = ((rvs_opc[1:0] == 2'b01) && eff_addr[0]) ||
                  (rvs_opc[1] && (eff_addr[1:0] != 2'b00));

  // Remember whether the accepted op is misaligned so it bypasses memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mis_q <= 1'b0;
    end else if (acc) begin
      mis_q <= mis_in;
    end
  end
`else
  assign mis_q = 1'b0;
`endif

  // Op capture and IDLE/MEM sequencing; the request is held from registers until completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      opc_q  <= 4'd0;
      tag_q  <= '0;
      addr_q <= 32'd0;
      rs2_q  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (acc) begin
            opc_q  <= rvs_opc;
            tag_q  <= rvs_tag;
            addr_q <= eff_addr;
            rs2_q  <= rvs_rs2;
            state  <= MEM;
          end
        end
        MEM: begin
          if (push) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pop = cdb_req && cdb_rdy;

  // Result FIFO pointers and occupancy; pointers wrap at DEPTH for any DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Result storage; contents are only observed while occupied, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_q[wptr] <= push_ent;
    end
  end

  // The single-outstanding rule reserves a slot before issue, so a full push is a design bug.
  assert property (@(posedge clk) disable iff (rst) !(push && (count == CNT_FULL)));

  assign head      = buf_q[rptr];
  assign cdb_req   = (count != '0);
  assign cdb_tag   = cdb_req ? head.tag  : '0;
  assign cdb_wdata = cdb_req ? head.data : 32'd0;
  assign cdb_exc   = cdb_req && head.exc;

endmodule

// File: tb/tb_lsu_pipe.sv
// Directed bench for lsu_pipe with a byte-level reference model and a CDB scoreboard.
// Latency: checks dmem request the cycle after accept and CDB result the cycle after dmem_resp.
// Backpressure: holds cdb_rdy low to fill the buffer, then drains and checks order.
module tb_lsu_pipe;

  logic        clk;
  logic        rst;
  logic        rvs_req;
  logic        rvs_rdy;
  logic [3:0]  rvs_opc;
  logic [3:0]  rvs_tag;
  logic [31:0] rvs_rs1;
  logic [31:0] rvs_rs2;
  logic [31:0] rvs_imm;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        cdb_req;
  logic        cdb_rdy;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_wdata;
  logic        cdb_exc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] data;
    logic        exc;
  } exp_t;

  exp_t exp_q[$];

  logic [31:0] cap_addr;
  logic [3:0]  cap_rmask;
  logic [3:0]  cap_wmask;
  logic [31:0] cap_wdata;

  lsu_pipe #(.TAG_W(4), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .rvs_req(rvs_req), .rvs_rdy(rvs_rdy), .rvs_opc(rvs_opc), .rvs_tag(rvs_tag),
    .rvs_rs1(rvs_rs1), .rvs_rs2(rvs_rs2), .rvs_imm(rvs_imm),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .cdb_req(cdb_req), .cdb_rdy(cdb_rdy), .cdb_tag(cdb_tag),
    .cdb_wdata(cdb_wdata), .cdb_exc(cdb_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: access width in bytes, naturally aligned byte offset inside the word.
  function automatic int m_size(input logic [3:0] opc);
    return (opc[1:0] == 2'b00) ? 1 : ((opc[1:0] == 2'b01) ? 2 : 4);
  endfunction

  function automatic int m_off(input logic [3:0] opc, input logic [31:0] addr);
    int n;
    n = m_size(opc);
    return (int'(addr[1:0]) / n) * n;
  endfunction

  function automatic logic [3:0] m_mask(input logic [3:0] opc, input logic [31:0] addr);
    logic [3:0] m;
    int n, o;
    n = m_size(opc);
    o = m_off(opc, addr);
    m = 4'b0000;
    for (int i = 0; i < n; i++) m[o + i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [3:0] opc, input logic [31:0] addr,
                                          input logic [31:0] rs2);
    logic [63:0] v;
    v = {32'd0, rs2} << (8 * m_off(opc, addr));
    return v[31:0];
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] opc, input logic [31:0] addr,
                                         input logic [31:0] rdata);
    logic [31:0] v;
    int n, o;
    n = m_size(opc);
    o = m_off(opc, addr);
    v = 32'd0;
    for (int i = 0; i < n; i++) v = v + (((rdata >> (8 * (o + i))) & 32'hFF) << (8 * i));
    if (!opc[2] && n < 4 && v[8 * n - 1]) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  // Scoreboard: every CDB handshake must match the oldest expected completion.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() == 0) chk("cdb_req_when_empty", 32'(cdb_req), 32'd0);
      if (cdb_req && cdb_rdy && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("cdb_tag", 32'(cdb_tag), 32'(e.tag));
        chk("cdb_wdata", cdb_wdata, e.data);
        chk("cdb_exc", 32'(cdb_exc), 32'(e.exc));
      end
    end
  end

  task automatic chk_req(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] rs2);
    chk("dmem_addr", dmem_addr, a & 32'hFFFF_FFFC);
    chk("dmem_rmask", 32'(dmem_rmask), opc[3] ? 32'd0 : 32'(m_mask(opc, a)));
    chk("dmem_wmask", 32'(dmem_wmask), opc[3] ? 32'(m_mask(opc, a)) : 32'd0);
    if (opc[3]) chk("dmem_wdata", dmem_wdata, m_wdata(opc, a, rs2));
  endtask

  // Present one op, answer its dmem request after k cycles, and queue the expected result.
  task automatic issue(input logic [3:0] opc, input logic [3:0] tag, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] imm, input logic [31:0] rdata,
                       input int k, input bit rdy_at_resp);
    logic [31:0] a;
    exp_t e;
    bit got;
    a = rs1 + imm;
    @(posedge clk); #1;
    rvs_req = 1'b1; rvs_opc = opc; rvs_tag = tag;
    rvs_rs1 = rs1; rvs_rs2 = rs2; rvs_imm = imm;
    got = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      if (rvs_rdy) got = 1'b1;
      @(posedge clk); #1;
    end
    rvs_req = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL accept_timeout: rvs_rdy stayed 0 for tag %0d, expected 1", tag);
      return;
    end
    repeat (k - 1) begin
      @(negedge clk); chk_req(opc, a, rs2);
      @(posedge clk); #1;
    end
    dmem_resp = 1'b1; dmem_rdata = rdata;
    if (rdy_at_resp) cdb_rdy = 1'b1;
    e.tag = tag; e.data = opc[3] ? 32'd0 : m_load(opc, a, rdata); e.exc = 1'b0;
    exp_q.push_back(e);
    @(negedge clk);
    chk_req(opc, a, rs2);
    cap_addr = dmem_addr; cap_rmask = dmem_rmask; cap_wmask = dmem_wmask; cap_wdata = dmem_wdata;
    @(posedge clk); #1;
    dmem_resp = 1'b0; dmem_rdata = 32'h5A5A_A5A5;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    @(posedge clk); #1; cdb_rdy = 1'b1;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      if (!cdb_req) done = 1'b1;
    end
    chk("drain_completed", 32'(done), 32'd1);
    chk("drain_model_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1; cdb_rdy = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rvs_req = 1'b0; rvs_opc = 4'd0; rvs_tag = 4'd0;
    rvs_rs1 = 32'd0; rvs_rs2 = 32'd0; rvs_imm = 32'd0;
    dmem_rdata = 32'd0; dmem_resp = 1'b0; cdb_rdy = 1'b0;

    // Outputs while reset is held.
    repeat (2) @(negedge clk);
    chk("rst_rvs_rdy", 32'(rvs_rdy), 32'd0);
    chk("rst_cdb_req", 32'(cdb_req), 32'd0);
    chk("rst_rmask", 32'(dmem_rmask), 32'd0);
    chk("rst_wmask", 32'(dmem_wmask), 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_cdb_tag", 32'(cdb_tag), 32'd0);
    chk("rst_cdb_wdata", cdb_wdata, 32'd0);
    chk("rst_cdb_exc", 32'(cdb_exc), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rvs_rdy", 32'(rvs_rdy), 32'd1);

    // Load word, one-cycle response; result must be on the CDB right after the response edge.
    issue(4'b0010, 4'd3, 32'h1000, 32'd0, 32'd4, 32'hDEAD_BEEF, 1, 1'b0);
    @(negedge clk);
    chk("lw_addr", cap_addr, 32'h1004);
    chk("lw_rmask", 32'(cap_rmask), 32'hF);
    chk("lw_wmask", 32'(cap_wmask), 32'h0);
    chk("lw_cdb_req", 32'(cdb_req), 32'd1);
    chk("lw_cdb_tag", 32'(cdb_tag), 32'd3);
    chk("lw_cdb_wdata", cdb_wdata, 32'hDEAD_BEEF);
    chk("lw_idle_rmask", 32'(dmem_rmask), 32'd0);
    drain();

    // Byte loads at offset 3, signed then unsigned.
    issue(4'b0000, 4'd5, 32'h2000, 32'd0, 32'd3, 32'h8011_2233, 2, 1'b0);
    @(negedge clk);
    chk("lb_rmask", 32'(cap_rmask), 32'h8);
    chk("lb_cdb_wdata", cdb_wdata, 32'hFFFF_FF80);
    drain();
    issue(4'b0100, 4'd5, 32'h2000, 32'd0, 32'd3, 32'h8011_2233, 1, 1'b0);
    @(negedge clk);
    chk("lbu_cdb_wdata", cdb_wdata, 32'h0000_0080);
    drain();

    // Store half at offset 2.
    issue(4'b1001, 4'd7, 32'h3000, 32'h0000_ABCD, 32'd2, 32'hFFFF_FFFF, 1, 1'b0);
    @(negedge clk);
    chk("sh_wmask", 32'(cap_wmask), 32'hC);
    chk("sh_rmask", 32'(cap_rmask), 32'h0);
    chk("sh_wdata", cap_wdata, 32'hABCD_0000);
    chk("sh_cdb_tag", 32'(cdb_tag), 32'd7);
    chk("sh_cdb_wdata", cdb_wdata, 32'd0);
    drain();

`ifndef LSU_MISALIGN_TRAP_EN
    // Negative offset wraps; misaligned half is forced to its natural lane.
    issue(4'b0001, 4'd2, 32'h0000_0100, 32'd0, 32'hFFFF_FFFF, 32'h8001_1234, 1, 1'b0);
    @(negedge clk);
    chk("lh_mis_addr", cap_addr, 32'h0000_00FC);
    chk("lh_mis_rmask", 32'(cap_rmask), 32'hC);
    chk("lh_mis_cdb_wdata", cdb_wdata, 32'hFFFF_8001);
    chk("lh_mis_cdb_exc", 32'(cdb_exc), 32'd0);
    drain();
`endif

    // Reserved size code behaves as a word store.
    issue(4'b1011, 4'd4, 32'h4000, 32'h1234_5678, 32'd0, 32'd0, 1, 1'b0);
    @(negedge clk);
    chk("sw_rsv_wmask", 32'(cap_wmask), 32'hF);
    chk("sw_rsv_wdata", cap_wdata, 32'h1234_5678);
    drain();

    // Fill both buffer entries with the CDB stalled, then drain in order.
    issue(4'b0010, 4'd1, 32'h10, 32'd0, 32'd0, 32'h1111_1111, 1, 1'b0);
    issue(4'b0101, 4'd2, 32'h20, 32'd0, 32'd2, 32'hBEEF_0000, 3, 1'b0);
    @(negedge clk);
    chk("full_rvs_rdy", 32'(rvs_rdy), 32'd0);
    chk("full_cdb_req", 32'(cdb_req), 32'd1);
    chk("full_head_tag", 32'(cdb_tag), 32'd1);
    chk("full_head_wdata", cdb_wdata, 32'h1111_1111);
    drain();
    @(negedge clk);
    chk("drained_rvs_rdy", 32'(rvs_rdy), 32'd1);

    // Push and pop on the same edge keeps one entry, now the newer op.
    issue(4'b0000, 4'd6, 32'h40, 32'd0, 32'd1, 32'h0000_7F00, 1, 1'b0);
    issue(4'b0100, 4'd8, 32'h40, 32'd0, 32'd2, 32'h00FF_0000, 1, 1'b1);
    @(negedge clk);
    chk("pushpop_cdb_req", 32'(cdb_req), 32'd1);
    chk("pushpop_head_tag", 32'(cdb_tag), 32'd8);
    chk("pushpop_head_wdata", cdb_wdata, 32'h0000_00FF);
    @(negedge clk);
    chk("pushpop_empty", 32'(cdb_req), 32'd0);
    @(posedge clk); #1; cdb_rdy = 1'b0;

    // Reset during MEM abandons the access; a late response must be ignored.
    @(posedge clk); #1;
    rvs_req = 1'b1; rvs_opc = 4'b0010; rvs_tag = 4'd4; rvs_rs1 = 32'h5000; rvs_imm = 32'd0;
    @(negedge clk);
    chk("abort_accept_rdy", 32'(rvs_rdy), 32'd1);
    @(posedge clk); #1; rvs_req = 1'b0;
    @(negedge clk);
    chk("abort_mem_rmask", 32'(dmem_rmask), 32'hF);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("abort_rst_rmask", 32'(dmem_rmask), 32'd0);
    chk("abort_rst_rdy", 32'(rvs_rdy), 32'd0);
    @(posedge clk); #1; rst = 1'b0; dmem_resp = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1; dmem_resp = 1'b0; cdb_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_cdb", 32'(cdb_req), 32'd0);
    end
    chk("abort_rvs_rdy", 32'(rvs_rdy), 32'd1);
    @(posedge clk); #1; cdb_rdy = 1'b0;

`ifdef LSU_MISALIGN_TRAP_EN
    // Misaligned word load traps without a memory access.
    begin
      exp_t e;
      @(posedge clk); #1;
      rvs_req = 1'b1; rvs_opc = 4'b0010; rvs_tag = 4'd9; rvs_rs1 = 32'h1000; rvs_imm = 32'd1;
      @(negedge clk);
      chk("trap_accept_rdy", 32'(rvs_rdy), 32'd1);
      @(posedge clk); #1; rvs_req = 1'b0;
      e.tag = 4'd9; e.data = 32'h1001; e.exc = 1'b1;
      exp_q.push_back(e);
      @(negedge clk);
      chk("trap_rmask", 32'(dmem_rmask), 32'd0);
      chk("trap_wmask", 32'(dmem_wmask), 32'd0);
      @(negedge clk);
      chk("trap_cdb_req", 32'(cdb_req), 32'd1);
      chk("trap_cdb_exc", 32'(cdb_exc), 32'd1);
      chk("trap_cdb_wdata", cdb_wdata, 32'h1001);
      chk("trap_cdb_tag", 32'(cdb_tag), 32'd9);
      drain();
    end
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
